dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU M-stage data interface and a word-oriented DMA requester (console/loader engine).
- The CPU has priority. The DMA is served in CPU-idle cycles.
- A starvation counter forces one DMA grant after STARVE_MAX consecutive denied cycles; during that cycle the CPU M-stage is stalled.
- Sits between the CPU's m_data_* ports and the DM instance.

Parameters:
- STARVE_MAX, 8: consecutive denied DMA-request cycles before a forced DMA grant (legal range 1..255).
- DM_LIMIT, 32'h0000_3000: DMA addresses at or above this value are rejected with dma_err.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_addr  in  32  CPU data address
- cpu_wdata  in  32  CPU write data, already byte-lane aligned
- cpu_byteen  in  4  CPU byte write enables; nonzero means store
- cpu_rd  in  1  CPU load in M stage
- cpu_rdata  out  32  read data to CPU (combinational from mem_rdata)
- cpu_stall  out  1  CPU must hold M stage and all earlier stages this cycle
- dma_req  in  1  DMA request, held until granted
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  32  DMA word address, bits [1:0] ignored
- dma_wdata  in  32  DMA write data (full word)
- dma_gnt  out  1  DMA owns the port this cycle
- dma_rvalid  out  1  registered read-data valid
- dma_rdata  out  32  registered read data
- dma_err  out  1  registered one-cycle pulse: granted DMA access was out of range
- mem_addr  out  32  DM address
- mem_wdata  out  32  DM write data
- mem_byteen  out  4  DM byte enables; write commits at clk edge
- mem_rdata  in  32  DM combinational read data

Behaviour:
- cpu_active = cpu_rd | (|cpu_byteen).
- force = (starve_cnt == STARVE_MAX).
- Ownership is combinational, evaluated each cycle:
  - force & dma_req: DMA owns. cpu_stall = cpu_active.
  - else if cpu_active: CPU owns. dma_gnt = 0, cpu_stall = 0.
  - else if dma_req: DMA owns, cpu_stall = 0.
  - else: idle. mem_byteen = 0, mem_addr = cpu_addr.
- CPU owns: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_byteen = cpu_byteen.
- DMA owns: mem_addr = {dma_addr[31:2], 2'b00}, mem_wdata = dma_wdata, mem_byteen = (dma_we & in_range) ? 4'hF : 4'h0.
- in_range = dma_addr < DM_LIMIT.
- cpu_rdata = mem_rdata in all cycles. It is only meaningful when the CPU owns the port.
- dma_gnt = DMA owns. The grant is single-cycle and completes the transaction. The DMA drops or changes its request at the next edge.
- Read path: on the edge ending a granted in-range read, dma_rvalid <= 1 and dma_rdata <= mem_rdata. Otherwise dma_rvalid <= 0 and dma_rdata holds. Read latency is exactly 1 cycle after dma_gnt.
- Error path: on the edge ending a granted out-of-range access, dma_err <= 1 for one cycle. No write occurs, and dma_rvalid stays 0.
- starve_cnt update, 8 bits, per edge:
  - dma_req & !dma_gnt: starve_cnt <= starve_cnt + 1, saturating at STARVE_MAX.
  - otherwise: starve_cnt <= 0.
- A forced grant therefore resets the counter. The CPU wins at least the next STARVE_MAX cycles. Back-to-back forced grants are impossible.
- A stalled CPU re-presents the same access next cycle. That cycle is not forced, so the CPU owns the port and the stall lasts exactly 1 cycle.
- Reset: starve_cnt = 0, dma_rvalid = 0, dma_rdata = 0, dma_err = 0. Combinational outputs follow the rules above from the first post-reset cycle.
- Reset during a granted cycle: a DMA write still commits, because the DM sees mem_byteen. No rvalid or err is produced.

Test Plan:
- No CPU activity, dma_req=1, dma_we=0, dma_addr=32'h0000_0104, DM[0x104]=32'hDEAD_BEEF -> dma_gnt=1 same cycle, mem_addr=32'h104; next cycle dma_rvalid=1, dma_rdata=32'hDEAD_BEEF.
- CPU sw every cycle (cpu_byteen=4'hF) while dma_req=1 write, STARVE_MAX=8 -> dma_gnt=0 for cycles 0..7; cycle 8 dma_gnt=1 and cpu_stall=1, DMA word written; cycle 9 CPU owns port with cpu_stall=0, starve_cnt=0.
- Simultaneous CPU sb (cpu_byteen=4'b0100) and DMA request, counter below max -> mem_byteen=4'b0100 from CPU, dma_gnt=0, starve_cnt increments by 1.
- DMA write to 32'h0000_3000 with no CPU activity -> dma_gnt=1, mem_byteen=0, next cycle dma_err=1 for one cycle, DM unchanged.
- Reset asserted with starve_cnt=5 and dma_rvalid=1 -> next cycle starve_cnt=0, dma_rvalid=0, dma_rdata=0, dma_err=0.
- dma_req deasserted for one cycle mid-starvation (starve_cnt=6) -> counter returns to 0; a re-raised request needs 8 more denied cycles before a forced grant.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// dm_port_arbiter_if : CPU, DMA and data-memory signal bundle for the arbiter
// Revision 1.0 : initial release
// ============================================================================
interface dm_port_arbiter_if;
  // CPU M-stage data side
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_rd;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  // DMA requester side
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_err;

  // Data-memory side
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_byteen, cpu_rd,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata, dma_err,
    output mem_addr, mem_wdata, mem_byteen,
    input  mem_rdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_byteen, cpu_rd,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
    input  mem_addr, mem_wdata, mem_byteen,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// dm_port_arbiter : CPU-priority sharing of the data-memory port with a DMA
//                   requester, plus a starvation counter forcing DMA grants.
// Revision 1.0 : initial release
// ============================================================================
module dm_port_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter logic [31:0] DM_LIMIT   = 32'h0000_3000
) (
  input  wire logic         clk,
  input  wire logic         reset,
  dm_port_arbiter_if.slave  bus
);

  localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);

  logic        w_cpu_active;
  logic        w_force;
  logic        w_dma_own;
  logic        w_cpu_own;
  logic        w_in_range;
  logic        w_dma_rd_ok;
  logic [31:0] w_dma_word_addr;
  logic [3:0]  w_dma_byteen;

  logic [7:0]  starve_cnt_d, starve_cnt_q;
  logic        dma_rvalid_d, dma_rvalid_q;
  logic [31:0] dma_rdata_d,  dma_rdata_q;
  logic        dma_err_d,    dma_err_q;

  // Ownership decision: a saturated counter lets the DMA pre-empt the CPU.
  always_comb begin
    w_cpu_active    = bus.cpu_rd | (|bus.cpu_byteen);
    w_force         = (starve_cnt_q == C_STARVE_MAX);
    w_dma_own       = bus.dma_req & (w_force | ~w_cpu_active);
    w_cpu_own       = w_cpu_active & ~w_dma_own;
    w_in_range      = (bus.dma_addr < DM_LIMIT);
    w_dma_rd_ok     = w_dma_own & ~bus.dma_we & w_in_range;
    w_dma_word_addr = {bus.dma_addr[31:2], 2'b00};
    w_dma_byteen    = (bus.dma_we & w_in_range) ? 4'hF : 4'h0;
  end

  assign bus.mem_addr   = w_dma_own ? w_dma_word_addr : bus.cpu_addr;
  assign bus.mem_wdata  = w_dma_own ? bus.dma_wdata   : bus.cpu_wdata;
  assign bus.mem_byteen = w_dma_own ? w_dma_byteen
                        : (w_cpu_own ? bus.cpu_byteen : 4'h0);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = w_dma_own & w_cpu_active;
  assign bus.dma_gnt    = w_dma_own;

  always_comb begin
    dma_rvalid_d = w_dma_rd_ok;
    dma_rdata_d  = w_dma_rd_ok ? bus.mem_rdata : dma_rdata_q;
    dma_err_d    = w_dma_own & ~w_in_range;
    starve_cnt_d = 8'd0;
    if (bus.dma_req & ~w_dma_own) begin
      starve_cnt_d = w_force ? C_STARVE_MAX : (starve_cnt_q + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 8'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= 32'd0;
      dma_err_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_err_q    <= dma_err_d;
    end
  end

  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_err    = dma_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dm_port_arbiter : directed and random checks of dm_port_arbiter against
//                      a transaction-level reference model.
// Revision 1.0 : initial release
// ============================================================================
module tb_dm_port_arbiter;
  localparam int          STARVE_MAX = 8;
  localparam logic [31:0] DM_LIMIT   = 32'h0000_3000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dm_port_arbiter_if bus ();

  dm_port_arbiter #(.STARVE_MAX(STARVE_MAX), .DM_LIMIT(DM_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT, and the model's private copy.
  logic [31:0] dm      [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] dm_merge;

  assign bus.mem_rdata = dm[bus.mem_addr[15:2]];

  always @(posedge clk) begin
    dm_merge = dm[bus.mem_addr[15:2]];
    for (int b = 0; b < 4; b++)
      if (bus.mem_byteen[b]) dm_merge[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    dm[bus.mem_addr[15:2]] <= dm_merge;
  end

  int          checks = 0;
  int          errors = 0;
  int          denied = 0;     // consecutive cycles the DMA request was refused
  logic        exp_rvalid = 1'b0;
  logic        exp_err    = 1'b0;
  logic [31:0] exp_rdata  = 32'd0;
  logic        obs_gnt, obs_stall;
  logic [3:0]  obs_byteen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: comb outputs checked mid-cycle, registered after the edge.
  task automatic step();
    bit          act, dwin, inr;
    logic [3:0]  eb;
    logic [31:0] ea, w;
    int          di, ci;
    @(negedge clk);
    act  = bus.cpu_rd || (bus.cpu_byteen != 4'h0);
    dwin = bus.dma_req && ((denied == STARVE_MAX) || !act);
    inr  = (bus.dma_addr < DM_LIMIT);
    di   = int'(bus.dma_addr[15:2]);
    ci   = int'(bus.cpu_addr[15:2]);
    if (dwin) begin
      ea = {bus.dma_addr[31:2], 2'b00};
      eb = (bus.dma_we && inr) ? 4'hF : 4'h0;
    end else begin
      ea = bus.cpu_addr;
      eb = act ? bus.cpu_byteen : 4'h0;
    end
    obs_gnt    = bus.dma_gnt;
    obs_stall  = bus.cpu_stall;
    obs_byteen = bus.mem_byteen;
    chk("dma_gnt",    {31'd0, bus.dma_gnt},   {31'd0, dwin});
    chk("cpu_stall",  {31'd0, bus.cpu_stall}, {31'd0, dwin && act});
    chk("mem_addr",   bus.mem_addr, ea);
    chk("mem_byteen", {28'd0, bus.mem_byteen}, {28'd0, eb});
    if (dwin) chk("mem_wdata", bus.mem_wdata, bus.dma_wdata);
    if (!dwin && bus.cpu_rd) chk("cpu_rdata", bus.cpu_rdata, ref_mem[ci]);

    @(posedge clk); #1;
    if (reset) begin
      exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
    end else begin
      exp_rvalid = dwin && !bus.dma_we && inr;
      exp_err    = dwin && !inr;
      if (exp_rvalid) exp_rdata = ref_mem[di];
    end
    if (dwin && bus.dma_we && inr) begin
      ref_mem[di] = bus.dma_wdata;
      chk("dm_dma_write", dm[di], ref_mem[di]);
    end else if (!dwin && act && bus.cpu_byteen != 4'h0) begin
      w = ref_mem[ci];
      for (int b = 0; b < 4; b++)
        if (bus.cpu_byteen[b]) w[8*b +: 8] = bus.cpu_wdata[8*b +: 8];
      ref_mem[ci] = w;
      chk("dm_cpu_write", dm[ci], ref_mem[ci]);
    end
    if (reset || !(bus.dma_req && !dwin)) denied = 0;
    else denied = (denied + 1 > STARVE_MAX) ? STARVE_MAX : denied + 1;
    chk("dma_rvalid", {31'd0, bus.dma_rvalid}, {31'd0, exp_rvalid});
    chk("dma_err",    {31'd0, bus.dma_err},    {31'd0, exp_err});
    chk("dma_rdata",  bus.dma_rdata, exp_rdata);
  endtask

  task automatic set_cpu(input logic rd, input logic [3:0] be, input logic [31:0] a);
    bus.cpu_rd = rd; bus.cpu_byteen = be; bus.cpu_addr = a; bus.cpu_wdata = $urandom;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  initial begin
    int   mism;
    bit   pend;
    for (int i = 0; i < 16384; i++) begin
      dm[i] = $urandom; ref_mem[i] = dm[i];
    end
    dm[32'h104 >> 2] = 32'hDEAD_BEEF; ref_mem[32'h104 >> 2] = 32'hDEAD_BEEF;
    set_cpu(1'b0, 4'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'd0, bus.dma_rvalid}, 32'd0);
    chk("rst_err",    {31'd0, bus.dma_err},    32'd0);
    chk("rst_rdata",  bus.dma_rdata, 32'd0);
    reset = 1'b0;

    // Idle CPU: DMA read granted at once, data one cycle later.
    set_dma(1'b1, 1'b0, 32'h0000_0104, 32'h0);
    step();
    chk("rd_gnt", {31'd0, obs_gnt}, 32'd1);
    chk("rd_rvalid", {31'd0, bus.dma_rvalid}, 32'd1);
    chk("rd_data", bus.dma_rdata, 32'hDEAD_BEEF);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Continuous CPU stores starve a DMA write until the forced grant.
    set_cpu(1'b0, 4'hF, 32'h0000_0200);
    set_dma(1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("starve_gnt",   {31'd0, obs_gnt},   (i == 8) ? 32'd1 : 32'd0);
      chk("starve_stall", {31'd0, obs_stall}, (i == 8) ? 32'd1 : 32'd0);
      if (i == 8) set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    end
    chk("starve_word", dm[32'h300 >> 2], 32'h1234_5678);

    // CPU byte store beats a fresh DMA request; starvation counts from here.
    set_cpu(1'b0, 4'b0100, 32'h0000_0208);
    set_dma(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) chk("sb_byteen", {28'd0, obs_byteen}, 32'h4);
      chk("sb_gnt", {31'd0, obs_gnt}, (i == 8) ? 32'd1 : 32'd0);
    end
    set_cpu(1'b0, 4'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Out-of-range DMA write: granted, suppressed, one-cycle error.
    set_dma(1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D);
    step();
    chk("oor_gnt",    {31'd0, obs_gnt}, 32'd1);
    chk("oor_byteen", {28'd0, obs_byteen}, 32'h0);
    chk("oor_err",    {31'd0, bus.dma_err}, 32'd1);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("oor_err_end", {31'd0, bus.dma_err}, 32'd0);
    chk("oor_dm", dm[32'h3000 >> 2], ref_mem[32'h3000 >> 2]);

    // Reset with a partly built starvation count, then a full fresh count.
    set_cpu(1'b1, 4'h0, 32'h0000_0400);
    set_dma(1'b1, 1'b0, 32'h0000_0104, 32'h0);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst5_rdata", bus.dma_rdata, 32'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rst5_gnt", {31'd0, obs_gnt}, (i == 8) ? 32'd1 : 32'd0);
    end

    // Reset during a granted write: the write lands, no status pulses.
    set_cpu(1'b0, 4'h0, 32'h0);
    set_dma(1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_dm", dm[32'h40 >> 2], 32'hA5A5_5A5A);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Request dropped mid-starvation restarts the count.
    set_cpu(1'b1, 4'h0, 32'h0000_0500);
    set_dma(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    repeat (6) step();
    bus.dma_req = 1'b0;
    step();
    bus.dma_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("drop_gnt", {31'd0, obs_gnt}, (i == 8) ? 32'd1 : 32'd0);
    end
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);

    // Random traffic; the DMA holds each request until it is granted.
    pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 3)
        0:       set_cpu(1'b0, 4'h0, 32'($urandom_range(0, 16'hFFFF)) & ~32'h3);
        1:       set_cpu(1'b1, 4'h0, 32'($urandom_range(0, 16'hFFFF)) & ~32'h3);
        default: set_cpu(1'b0, 4'($urandom_range(1, 15)), 32'($urandom_range(0, 16'hFFFF)) & ~32'h3);
      endcase
      if (!pend && ($urandom % 2 == 0)) begin
        set_dma(1'b1, 1'($urandom % 2), 32'($urandom_range(0, 32'h3FFF)), $urandom);
        pend = 1'b1;
      end
      bus.dma_req = pend;
      step();
      if (obs_gnt) pend = 1'b0;
    end

    mism = 0;
    for (int i = 0; i < 16384; i++) if (dm[i] !== ref_mem[i]) mism++;
    chk("dm_final", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
